// File: rtl/lsu.sv
// RV32I load/store unit: one word-aligned memory transaction per request,
// with lane steering for stores, sign/zero extension for loads, and early exceptions.
module lsu #(
    parameter int N_BITS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [N_BITS-1:0] req_addr,
    input  logic [N_BITS-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [N_BITS-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        mem_wstrb,
    output logic [N_BITS-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [N_BITS-1:0] mem_rdata,
    output logic              resp_valid,
    output logic              resp_wb,
    output logic [N_BITS-1:0] resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              exc_misaligned,
    output logic              exc_illegal,
    output logic [1:0]        dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // a memory request transfers where mem_req_valid && mem_req_ready, and its
    // response is the first mem_resp_valid seen in WAIT.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state, state_nx;
    logic              up_q;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [N_BITS-1:0] addr_q;
    logic [N_BITS-1:0] wdata_q;
    logic [N_BITS-1:0] rdata_q;
    logic [4:0]        rd_q;
    logic              mis_q;
    logic              ill_q;

    logic              accept;
    logic              req_ill;
    logic              req_mis;
    logic [1:0]        o;
    logic [N_BITS-1:0] lane_wdata;
    logic [3:0]        lane_wstrb;
    logic [N_BITS-1:0] shifted;
    logic [N_BITS-1:0] load_ext;
    logic              in_req;
    logic              in_done;

    assign accept = req_valid && req_ready;

    always_comb begin
        req_ill = 1'b0;
        req_mis = 1'b0;
        if (req_we)
            req_ill = req_funct3[2] || (req_funct3[1:0] == 2'b11);
        else
            req_ill = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        req_mis = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                  ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = (req_ill || req_mis) ? DONE : REQ;
            REQ:     if (mem_req_ready) state_nx = WAIT;
            WAIT:    if (mem_resp_valid) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o          = addr_q[1:0];
        lane_wdata = wdata_q;
        lane_wstrb = 4'b1111;
        case (f3_q[1:0])
            2'b00: begin
                lane_wdata = {4{wdata_q[7:0]}};
                lane_wstrb = 4'b0001 << o;
            end
            2'b01: begin
                lane_wdata = {2{wdata_q[15:0]}};
                lane_wstrb = 4'b0011 << o;
            end
            default: begin
                lane_wdata = wdata_q;
                lane_wstrb = 4'b1111;
            end
        endcase
        shifted = mem_rdata >> {o, 3'b000};
        case (f3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            up_q    <= 1'b0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rd_q    <= 5'd0;
            mis_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state <= state_nx;
            up_q  <= 1'b1;
            if (accept) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rd_q    <= req_rd;
                ill_q   <= req_ill;
                mis_q   <= req_mis && !req_ill;
                rdata_q <= '0;
            end
            if (state == WAIT && mem_resp_valid)
                rdata_q <= we_q ? '0 : load_ext;
        end
    end

    // Memory-side outputs are only driven while the request is presented.
    assign in_req         = (state == REQ);
    assign in_done        = (state == DONE);
    assign req_ready      = up_q && (state == IDLE);
    assign mem_req_valid  = in_req;
    assign mem_addr       = in_req ? {addr_q[N_BITS-1:2], 2'b00} : '0;
    assign mem_we         = in_req && we_q;
    assign mem_wstrb      = (in_req && we_q) ? lane_wstrb : 4'd0;
    assign mem_wdata      = (in_req && we_q) ? lane_wdata : '0;
    assign resp_valid     = in_done;
    assign resp_wb        = in_done && !we_q && !ill_q && !mis_q;
    assign resp_rdata     = in_done ? rdata_q : '0;
    assign resp_rd        = rd_q;
    assign exc_misaligned = in_done && mis_q;
    assign exc_illegal    = in_done && ill_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: reset, load extension, store lanes, exceptions,
// memory backpressure and reset in the middle of a transaction.
module tb_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_wb;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        exc_misaligned;
    logic        exc_illegal;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // Observations captured by the transaction driver.
    bit          t_saw_mem;
    int          t_req_cycles;
    bit          t_unstable;
    bit          t_ready_hi;
    int          t_resp_cyc;
    logic [31:0] t_mem_addr;
    logic        t_mem_we;
    logic [3:0]  t_wstrb;
    logic [31:0] t_wdata;
    logic        t_wb;
    logic [31:0] t_rdata;
    logic [4:0]  t_rd;
    logic        t_mis;
    logic        t_ill;

    lsu #(.N_BITS(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_rd        (req_rd),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wstrb     (mem_wstrb),
        .mem_wdata     (mem_wdata),
        .mem_resp_valid(mem_resp_valid),
        .mem_rdata     (mem_rdata),
        .resp_valid    (resp_valid),
        .resp_wb       (resp_wb),
        .resp_rdata    (resp_rdata),
        .resp_rd       (resp_rd),
        .exc_misaligned(exc_misaligned),
        .exc_illegal   (exc_illegal),
        .dbg_state     (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: present one request at a negedge, then play memory (ready after
    // ready_wait presented cycles, response one cycle after acceptance).
    // Cycle numbering: accept edge is edge 0, cycle 1 follows it.
    task automatic transact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] rd,
                            input logic [31:0] rdata, input int ready_wait, input bit inject);
        int acc_cyc;
        bit got;
        t_saw_mem = 0; t_req_cycles = 0; t_unstable = 0; t_ready_hi = 0; t_resp_cyc = -1;
        t_mem_addr = 'x; t_mem_we = 'x; t_wstrb = 'x; t_wdata = 'x;
        t_wb = 'x; t_rdata = 'x; t_rd = 'x; t_mis = 'x; t_ill = 'x;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
        req_wdata = wdata; req_rd = rd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        acc_cyc = -1;
        got = 0;
        for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
            mem_req_ready = 1'b0;
            mem_resp_valid = 1'b0;
            if (req_ready) t_ready_hi = 1;
            if (mem_req_valid) begin
                if (!t_saw_mem) begin
                    t_mem_addr = mem_addr; t_mem_we = mem_we;
                    t_wstrb = mem_wstrb; t_wdata = mem_wdata;
                end else if (mem_addr !== t_mem_addr || mem_we !== t_mem_we ||
                             mem_wstrb !== t_wstrb || mem_wdata !== t_wdata) begin
                    t_unstable = 1;
                end
                t_saw_mem = 1;
                t_req_cycles++;
                if (t_req_cycles > ready_wait) begin
                    mem_req_ready = 1'b1;
                    acc_cyc = cyc;
                end else if (inject && t_req_cycles == 2) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata = 32'h5555_AAAA;
                end
            end
            if (acc_cyc >= 0 && cyc == acc_cyc + 1) begin
                mem_resp_valid = 1'b1;
                mem_rdata = rdata;
            end
            if (resp_valid) begin
                got = 1;
                t_resp_cyc = cyc;
                t_wb = resp_wb; t_rdata = resp_rdata; t_rd = resp_rd;
                t_mis = exc_misaligned; t_ill = exc_illegal;
            end
            @(negedge clk);
        end
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, mem_req_valid, resp_valid, resp_wb, exc_misaligned, exc_illegal} !== 6'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 000000",
                     {req_ready, mem_req_valid, resp_valid, resp_wb, exc_misaligned, exc_illegal});
        end
        checks++;
        if ({mem_addr, mem_wdata, resp_rdata, mem_wstrb, resp_rd, dbg_state} !== '0) begin
            errors++;
            $display("FAIL reset_data addr %h wdata %h rdata %h strb %b rd %h state %0d exp all 0",
                     mem_addr, mem_wdata, resp_rdata, mem_wstrb, resp_rd, dbg_state);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_rise got %b exp 1", req_ready);
        end
    endtask

    task automatic test_lw;
        transact(1'b0, 3'b010, 32'h100, 32'h0, 5'd7, 32'hDEAD_BEEF, 0, 0);
        checks++;
        if (t_mem_addr !== 32'h100 || t_wstrb !== 4'b0000 || t_mem_we !== 1'b0) begin
            errors++;
            $display("FAIL lw_mem_req got addr %h strb %b we %b exp 00000100 0000 0", t_mem_addr, t_wstrb, t_mem_we);
        end
        checks++;
        if (t_resp_cyc !== 3) begin
            errors++;
            $display("FAIL lw_latency got %0d exp 3", t_resp_cyc);
        end
        checks++;
        if (t_wb !== 1'b1 || t_rdata !== 32'hDEAD_BEEF || t_rd !== 5'd7) begin
            errors++;
            $display("FAIL lw_resp got wb %b data %h rd %0d exp 1 deadbeef 7", t_wb, t_rdata, t_rd);
        end
        checks++;
        if (t_ready_hi !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL lw_ready busy_high %b cycle4 %b exp 0 1", t_ready_hi, req_ready);
        end
    endtask

    task automatic test_load_ext;
        logic [2:0]  f3s  [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b101, 3'b000};
        logic [31:0] adrs [7] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101, 32'h102, 32'h102};
        logic [31:0] exps [7] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01,
                                  32'h0000_007F, 32'h0000_80FF, 32'hFFFF_FFFF};
        for (int i = 0; i < 7; i++) begin
            transact(1'b0, f3s[i], adrs[i], 32'h0, 5'd3, 32'h80FF_7F01, 0, 0);
            checks++;
            if (t_rdata !== exps[i] || t_wb !== 1'b1 || t_mem_addr !== {adrs[i][31:2], 2'b00}) begin
                errors++;
                $display("FAIL load_ext_%0d got data %h wb %b addr %h exp %h 1 %h",
                         i, t_rdata, t_wb, t_mem_addr, exps[i], {adrs[i][31:2], 2'b00});
            end
        end
    endtask

    task automatic test_store;
        transact(1'b1, 3'b000, 32'h201, 32'h1234_5678, 5'd9, 32'hFFFF_FFFF, 0, 0);
        checks++;
        if (t_mem_addr !== 32'h200 || t_wstrb !== 4'b0010 || t_wdata !== 32'h7878_7878 || t_mem_we !== 1'b1) begin
            errors++;
            $display("FAIL sb_lanes got addr %h strb %b data %h we %b exp 00000200 0010 78787878 1",
                     t_mem_addr, t_wstrb, t_wdata, t_mem_we);
        end
        checks++;
        if (t_wb !== 1'b0 || t_rdata !== 32'h0 || t_resp_cyc !== 3) begin
            errors++;
            $display("FAIL sb_resp got wb %b data %h cyc %0d exp 0 00000000 3", t_wb, t_rdata, t_resp_cyc);
        end
        transact(1'b1, 3'b001, 32'h202, 32'h1234_5678, 5'd9, 32'hFFFF_FFFF, 0, 0);
        checks++;
        if (t_mem_addr !== 32'h200 || t_wstrb !== 4'b1100 || t_wdata !== 32'h5678_5678 ||
            t_wb !== 1'b0 || t_rdata !== 32'h0) begin
            errors++;
            $display("FAIL sh_lanes got addr %h strb %b data %h wb %b rdata %h exp 00000200 1100 56785678 0 00000000",
                     t_mem_addr, t_wstrb, t_wdata, t_wb, t_rdata);
        end
        transact(1'b1, 3'b010, 32'h204, 32'hCAFE_F00D, 5'd9, 32'h0, 0, 0);
        checks++;
        if (t_mem_addr !== 32'h204 || t_wstrb !== 4'b1111 || t_wdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL sw_lanes got addr %h strb %b data %h exp 00000204 1111 cafef00d",
                     t_mem_addr, t_wstrb, t_wdata);
        end
    endtask

    task automatic test_exceptions;
        logic        wes  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]  f3s  [6] = '{3'b010, 3'b001, 3'b011, 3'b110, 3'b101, 3'b010};
        logic [31:0] adrs [6] = '{32'h102, 32'h101, 32'h100, 32'h100, 32'h101, 32'h201};
        logic        mis  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        ill  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            transact(wes[i], f3s[i], adrs[i], 32'hFFFF_FFFF, 5'd5, 32'h1234_5678, 0, 0);
            checks++;
            if (t_mis !== mis[i] || t_ill !== ill[i] || t_resp_cyc !== 1 || t_saw_mem !== 1'b0 ||
                t_wb !== 1'b0 || t_rdata !== 32'h0) begin
                errors++;
                $display("FAIL exc_%0d got mis %b ill %b cyc %0d memreq %b wb %b data %h exp %b %b 1 0 0 00000000",
                         i, t_mis, t_ill, t_resp_cyc, t_saw_mem, t_wb, t_rdata, mis[i], ill[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        transact(1'b1, 3'b010, 32'h300, 32'hA5A5_5A5A, 5'd4, 32'h0, 5, 1);
        checks++;
        if (t_req_cycles !== 6 || t_unstable !== 1'b0) begin
            errors++;
            $display("FAIL bp_stable got req_cycles %0d unstable %b exp 6 0", t_req_cycles, t_unstable);
        end
        checks++;
        if (t_mem_addr !== 32'h300 || t_wdata !== 32'hA5A5_5A5A || t_wstrb !== 4'b1111) begin
            errors++;
            $display("FAIL bp_req got addr %h data %h strb %b exp 00000300 a5a55a5a 1111",
                     t_mem_addr, t_wdata, t_wstrb);
        end
        checks++;
        if (t_resp_cyc !== 8 || t_ready_hi !== 1'b0) begin
            errors++;
            $display("FAIL bp_latency got cyc %0d ready_high %b exp 8 0", t_resp_cyc, t_ready_hi);
        end
        transact(1'b0, 3'b010, 32'h304, 32'h0, 5'd6, 32'h0BAD_F00D, 2, 1);
        checks++;
        if (t_resp_cyc !== 5 || t_rdata !== 32'h0BAD_F00D || t_wb !== 1'b1) begin
            errors++;
            $display("FAIL bp_load got cyc %0d data %h wb %b exp 5 0badf00d 1", t_resp_cyc, t_rdata, t_wb);
        end
    endtask

    task automatic test_reset_mid;
        bit late_resp;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400; req_rd = 5'd11;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        checks++;
        if (dbg_state !== 2'd2) begin
            errors++;
            $display("FAIL mid_in_wait got state %0d exp 2", dbg_state);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, mem_req_valid, resp_valid, resp_wb, exc_misaligned, exc_illegal} !== 6'd0 ||
            {mem_addr, resp_rdata, resp_rd, dbg_state} !== '0) begin
            errors++;
            $display("FAIL mid_async_reset got ctrl %b addr %h rdata %h rd %h state %0d exp all 0",
                     {req_ready, mem_req_valid, resp_valid, resp_wb, exc_misaligned, exc_illegal},
                     mem_addr, resp_rdata, resp_rd, dbg_state);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h7777_7777;
        late_resp = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            if (resp_valid || dbg_state != 2'd0) late_resp = 1;
        end
        checks++;
        if (late_resp !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_late_resp got spurious %b ready %b exp 0 1", late_resp, req_ready);
        end
        transact(1'b0, 3'b100, 32'h402, 32'h0, 5'd12, 32'h00C3_0000, 0, 0);
        checks++;
        if (t_resp_cyc !== 3 || t_rdata !== 32'h0000_00C3 || t_rd !== 5'd12 || t_wb !== 1'b1) begin
            errors++;
            $display("FAIL mid_recover got cyc %0d data %h rd %0d wb %b exp 3 000000c3 12 1",
                     t_resp_cyc, t_rdata, t_rd, t_wb);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'd0;
        test_reset;
        test_lw;
        test_load_ext;
        test_store;
        test_exceptions;
        test_backpressure;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the RV32I core, directly downstream of the ALU in the execute stage. It takes the ALU result as the effective address plus the rs2 store data. It performs one word-aligned data-memory transaction over a valid/ready request, valid response interface. It returns sign/zero-extended load data or a store completion to writeback, and flags misaligned and illegal accesses without touching memory.

## Interface
- N_BITS, 32: datapath width; only 32 is supported.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  execute stage presents a memory op.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- req_addr  in  N_BITS  effective address (ALU out).
- req_wdata  in  N_BITS  store data (rs2).
- req_rd  in  5  load destination register.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  N_BITS  {addr[31:2], 2'b00}.
- mem_we  out  1  store.
- mem_wstrb  out  4  byte enables; 0 for loads.
- mem_wdata  out  N_BITS  lane-replicated store data; 0 for loads.
- mem_resp_valid  in  1  memory response; one per accepted request, loads and stores alike.
- mem_rdata  in  N_BITS  raw load word.
- resp_valid  out  1  one-cycle completion pulse.
- resp_wb  out  1  write resp_rdata to resp_rd (successful load only).
- resp_rdata  out  N_BITS  extended load data.
- resp_rd  out  5  captured req_rd.
- exc_misaligned  out  1  valid with resp_valid.
- exc_illegal  out  1  valid with resp_valid.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: on accept, capture we, funct3, addr, wdata and rd.
    - Illegal funct3 goes to DONE with exc_illegal. Illegal means a load with 011, 110 or 111, or a store with 011 or 1xx.
    - Misaligned goes to DONE with exc_misaligned. Misaligned means halfword with addr[0]=1, or word with addr[1:0]≠0.
    - Otherwise go to REQ. Illegal takes priority over misaligned.
  - REQ: mem_req_valid=1 with stable addr, we, wstrb and wdata until mem_req_ready; then go to WAIT.
  - WAIT: on mem_resp_valid, register the extended data and go to DONE.
  - DONE: resp_valid=1 for exactly one cycle, then go to IDLE.
- Store lanes, with o = addr[1:0]:
  - SB: wdata = {4{wdata[7:0]}}, wstrb = 4'b0001<<o.
  - SH: wdata = {2{wdata[15:0]}}, wstrb = 4'b0011<<o.
  - SW: wdata unchanged, wstrb = 4'b1111.
- Load extraction: shifted = mem_rdata >> (8*o).
  - LB sign-extends shifted[7]; LBU zero-extends shifted[7:0].
  - LH sign-extends shifted[15]; LHU zero-extends shifted[15:0].
  - LW passes the word through.
- resp_wb = 1 only for a load with no exception. For stores and exceptions, resp_rdata = 0.
- mem_resp_valid is ignored in every state except WAIT. Memory must not respond in the same cycle it accepts a request.

## Timing
- Reset values: all outputs 0, state IDLE. req_ready therefore rises in the first cycle after reset deassertion.
- Asserting rst_n low mid-transaction aborts immediately, with no resp_valid. A late mem_resp_valid after reset is ignored.
- Accept at edge 0, then:
  - mem_req_valid from cycle 1.
  - With mem_req_ready in cycle 1 and mem_resp_valid in cycle 2, resp_valid is in cycle 3.
  - The next accept is possible in cycle 4.
- Total latency = 3 + (mem_req_ready wait cycles) + (response wait cycles beyond 1).
- Exception path: accept at edge 0, resp_valid in cycle 1, no mem_req_valid.
- One outstanding transaction only. req_ready is 0 from accept through DONE.

## Test plan
- Memory ready immediately, LW at addr 0x100, mem_rdata 0xDEADBEEF -> mem_addr 0x100, wstrb 0, resp_valid in cycle 3, resp_wb=1, resp_rdata 0xDEADBEEF, resp_rd matches.
- Byte and halfword extraction from mem_rdata 0x80FF7F01:
  - LB at 0x103 -> 0xFFFFFF80; LBU at 0x103 -> 0x00000080.
  - LH at 0x102 -> 0xFFFF80FF; LHU at 0x100 -> 0x00007F01.
- SB wdata 0x12345678 at 0x201 -> mem_addr 0x200, wstrb 0010, mem_wdata 0x78787878. Then SH at 0x202 -> wstrb 1100, mem_wdata 0x56785678. Both give resp_wb=0.
- Exception paths, none producing mem_req_valid:
  - LW at 0x102 -> exc_misaligned, resp_valid in cycle 1.
  - LH at 0x101 -> exc_misaligned.
  - Load funct3 011 -> exc_illegal.
- Backpressure: hold mem_req_ready low 5 cycles -> mem_req_valid, mem_addr and mem_wdata stay stable. Inject mem_resp_valid during REQ -> ignored. Also check req_ready stays 0 throughout.
- Reset during WAIT -> all outputs 0 asynchronously. A mem_resp_valid after release produces no resp_valid, and a new request is accepted normally.
